// File: rtl/apb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter_if
//   APB bus bundle between the arbiter (master side) and a single APB
//   completer (slave side).
//
//   Signals:
//     psel, penable, pwrite  - transfer control, driven by the master
//     paddr[11:0]            - register address, driven by the master
//     pstrb[3:0]             - write byte strobes, driven by the master
//     pwdata[31:0]           - write data, driven by the master
//     prdata[31:0]           - read data, driven by the completer
//     pready                 - transfer complete, driven by the completer
//     pslverr                - transfer error, driven by the completer
// ---------------------------------------------------------------------------
interface apb_master_arbiter_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pstrb, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pstrb, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//   Two-requester APB master. Each requester holds req_valid high until it
//   receives its one-cycle req_done pulse. A round-robin arbiter picks one
//   eligible requester in IDLE, the FSM then runs a standard APB
//   SETUP/ACCESS transfer and returns the completion response.
//
//   Parameters:
//     TIMEOUT_CYCLES - ACCESS wait cycles (pready=0) tolerated before the
//                      transfer is aborted with an error. Only used when the
//                      APB_TIMEOUT_EN macro is defined.
//
//   Optional feature:
//     `define APB_TIMEOUT_EN enables the ACCESS wait-state timeout. Without
//     it ACCESS waits for pready indefinitely.
//
//   Ports:
//     clk              - clock, all state on the rising edge
//     preset           - asynchronous active-high reset
//     req_valid[1:0]   - per-requester request
//     req_write[1:0]   - per-requester direction, 1 = write
//     req_addr[23:0]   - {req1 addr[11:0], req0 addr[11:0]}
//     req_wdata[63:0]  - {req1 wdata, req0 wdata}
//     req_strb[7:0]    - {req1 strb, req0 strb}
//     req_done[1:0]    - one-cycle completion pulse per requester
//     rsp_rdata[31:0]  - read data, valid with req_done
//     rsp_err          - error flag, valid with req_done
//     apb              - APB master bus (apb_master_arbiter_if.master)
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        preset,
  input  logic [1:0]                  req_valid,
  input  logic [1:0]                  req_write,
  input  logic [23:0]                 req_addr,
  input  logic [63:0]                 req_wdata,
  input  logic [7:0]                  req_strb,
  output logic [1:0]                  req_done,
  output logic [31:0]                 rsp_rdata,
  output logic                        rsp_err,
  apb_master_arbiter_if.master        apb
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t      state_q,   state_d;
  logic        psel_q,    psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q,  pwrite_d;
  logic [11:0] paddr_q,   paddr_d;
  logic [3:0]  pstrb_q,   pstrb_d;
  logic [31:0] pwdata_q,  pwdata_d;
  logic [1:0]  done_q,    done_d;
  logic [31:0] rdata_q,   rdata_d;
  logic        err_q,     err_d;
  logic        grant_q,   grant_d;
  logic        last_q,    last_d;

  logic [1:0]  eligible;
  logic        winner;

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] cnt_q, cnt_d;
`endif

  // A requester whose done pulse is still visible has just been served and
  // must sit out this IDLE cycle; this also guarantees the one-cycle gap
  // between back-to-back transfers.
  assign eligible = req_valid & ~done_q;

  // Tie goes to whoever was not granted last; otherwise the lone requester.
  always_comb begin
    winner = 1'b0;
    if (eligible == 2'b11) begin
      winner = ~last_q;
    end else begin
      winner = eligible[1];
    end
  end

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pstrb_d   = pstrb_q;
    pwdata_d  = pwdata_q;
    grant_d   = grant_q;
    last_d    = last_q;
    // Response outputs are pulses: zero unless a completion happens now.
    done_d    = 2'b00;
    rdata_d   = 32'h0;
    err_d     = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (|eligible) begin
          state_d  = ST_SETUP;
          psel_d   = 1'b1;
          grant_d  = winner;
          last_d   = winner;
          pwrite_d = winner ? req_write[1] : req_write[0];
          paddr_d  = winner ? req_addr[23:12] : req_addr[11:0];
          // Reads drive zero strobes and data so the bus never carries
          // stale write payload during a read.
          if (winner ? req_write[1] : req_write[0]) begin
            pstrb_d  = winner ? req_strb[7:4]    : req_strb[3:0];
            pwdata_d = winner ? req_wdata[63:32] : req_wdata[31:0];
          end else begin
            pstrb_d  = 4'h0;
            pwdata_d = 32'h0;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      ST_ACCESS: begin
        if (apb.pready) begin
          state_d          = ST_IDLE;
          psel_d           = 1'b0;
          penable_d        = 1'b0;
          done_d[grant_q]  = 1'b1;
          err_d            = apb.pslverr;
          // Read data is only meaningful for a read that completed cleanly.
          rdata_d          = (!pwrite_q && !apb.pslverr) ? apb.prdata : 32'h0;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          // This is the last tolerated wait cycle: abandon the transfer and
          // report it as an error to the requester.
          state_d         = ST_IDLE;
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          done_d[grant_q] = 1'b1;
          err_d           = 1'b1;
          rdata_d         = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // Last-grant pointer resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state_q   <= ST_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 12'h0;
      pstrb_q   <= 4'h0;
      pwdata_q  <= 32'h0;
      done_q    <= 2'b00;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pstrb_q   <= pstrb_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pstrb   = pstrb_q;
  assign apb.pwdata  = pwdata_q;

  assign req_done    = done_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

  logic        clk;
  logic        preset;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [23:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic [1:0]  req_done;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_vec;
  int n_err;

  apb_master_arbiter_if apb_if ();

  apb_master_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_done  (req_done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          r;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] prdata;
    logic        slverr;
    int          waits;
    logic [1:0]  exp_done;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_pwdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
  endtask

  task automatic drive_req(input int r, input logic wr, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    req_valid[r]          = 1'b1;
    req_write[r]          = wr;
    req_addr[12*r +: 12]  = addr;
    req_wdata[32*r +: 32] = wdata;
    req_strb[4*r +: 4]    = strb;
  endtask

  task automatic do_reset();
    @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    preset = 1'b0;
  endtask

  // Single transfer from one requester, completer inserts v.waits wait states.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive_req(v.r, v.wr, v.addr, v.wdata, v.strb);
    apb_if.pready  = 1'b0;
    apb_if.prdata  = v.prdata;
    apb_if.pslverr = v.slverr;
    @(negedge clk);
    chk("setup_psel",    {31'b0, apb_if.psel},    32'd1);
    chk("setup_penable", {31'b0, apb_if.penable}, 32'd0);
    chk("setup_paddr",   {20'b0, apb_if.paddr},   {20'b0, v.addr});
    chk("setup_pwrite",  {31'b0, apb_if.pwrite},  {31'b0, v.wr});
    chk("setup_pstrb",   {28'b0, apb_if.pstrb},   {28'b0, v.exp_pstrb});
    chk("setup_pwdata",  apb_if.pwdata,           v.exp_pwdata);
    for (int j = 1; j <= v.waits + 1; j++) begin
      @(negedge clk);
      chk("access_penable", {31'b0, apb_if.penable}, 32'd1);
      chk("access_psel",    {31'b0, apb_if.psel},    32'd1);
      chk("access_paddr",   {20'b0, apb_if.paddr},   {20'b0, v.addr});
      chk("access_pwdata",  apb_if.pwdata,           v.exp_pwdata);
      chk("access_no_done", {30'b0, req_done},       32'd0);
      apb_if.pready = (j == v.waits + 1);
    end
    @(negedge clk);
    chk("done_psel",    {31'b0, apb_if.psel},    32'd0);
    chk("done_penable", {31'b0, apb_if.penable}, 32'd0);
    chk("done_pulse",   {30'b0, req_done},       {30'b0, v.exp_done});
    chk("done_rdata",   rsp_rdata,               v.exp_rdata);
    chk("done_err",     {31'b0, rsp_err},        {31'b0, v.exp_err});
    chk("done_paddr_hold", {20'b0, apb_if.paddr}, {20'b0, v.addr});
    chk("done_pwdata_hold", apb_if.pwdata,        v.exp_pwdata);
    clear_req();
    apb_if.pready = 1'b0;
    @(negedge clk);
    chk("post_done",  {30'b0, req_done}, 32'd0);
    chk("post_rdata", rsp_rdata,         32'd0);
    chk("post_err",   {31'b0, rsp_err},  32'd0);
    chk("post_psel",  {31'b0, apb_if.psel}, 32'd0);
  endtask

  initial begin
    int k;
    bit seen_bad;
    n_vec = 0;
    n_err = 0;
    preset = 1'b1;
    clear_req();
    apb_if.prdata  = 32'h0;
    apb_if.pready  = 1'b0;
    apb_if.pslverr = 1'b0;

    //              r  wr    addr    wdata         strb  prdata        err waits done   rdata         err pstrb pwdata
    vecs[0] = '{0, 1'b0, 12'h004, 32'h1111_2222, 4'hF, 32'hA5A5_0055, 1'b0, 0, 2'b01, 32'hA5A5_0055, 1'b0, 4'h0, 32'h0};
    vecs[1] = '{1, 1'b1, 12'h123, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 1'b0, 5, 2'b10, 32'h0,         1'b0, 4'hF, 32'hDEAD_BEEF};
    vecs[2] = '{0, 1'b0, 12'hFFC, 32'h0,         4'h0, 32'hFFFF_0000, 1'b1, 0, 2'b01, 32'h0,         1'b1, 4'h0, 32'h0};
    vecs[3] = '{0, 1'b1, 12'h008, 32'h1122_3344, 4'h5, 32'h0BAD_0BAD, 1'b1, 2, 2'b01, 32'h0,         1'b1, 4'h5, 32'h1122_3344};
    vecs[4] = '{1, 1'b0, 12'h800, 32'hCAFE_F00D, 4'h3, 32'h0000_00FF, 1'b0, 1, 2'b10, 32'h0000_00FF, 1'b0, 4'h0, 32'h0};
    vecs[5] = '{1, 1'b1, 12'h7FF, 32'h8000_0001, 4'h8, 32'hFFFF_FFFF, 1'b0, 0, 2'b10, 32'h0,         1'b0, 4'h8, 32'h8000_0001};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_psel",    {31'b0, apb_if.psel},    32'd0);
    chk("rst_penable", {31'b0, apb_if.penable}, 32'd0);
    chk("rst_pwrite",  {31'b0, apb_if.pwrite},  32'd0);
    chk("rst_paddr",   {20'b0, apb_if.paddr},   32'd0);
    chk("rst_pstrb",   {28'b0, apb_if.pstrb},   32'd0);
    chk("rst_pwdata",  apb_if.pwdata,           32'd0);
    chk("rst_done",    {30'b0, req_done},       32'd0);
    chk("rst_rdata",   rsp_rdata,               32'd0);
    chk("rst_err",     {31'b0, rsp_err},        32'd0);
    preset = 1'b0;

    // Both requesters after reset: req0 first, one IDLE cycle, then req1.
    @(negedge clk);
    drive_req(0, 1'b1, 12'h000, 32'h0000_AAAA, 4'h3);
    drive_req(1, 1'b1, 12'h008, 32'hBBBB_0000, 4'hC);
    apb_if.pready = 1'b1;
    @(negedge clk);
    chk("tie_setup_psel",  {31'b0, apb_if.psel},  32'd1);
    chk("tie_first_paddr", {20'b0, apb_if.paddr}, 32'h000);
    chk("tie_first_pwdata", apb_if.pwdata,        32'h0000_AAAA);
    chk("tie_first_pstrb", {28'b0, apb_if.pstrb}, 32'h3);
    @(negedge clk);
    chk("tie_first_penable", {31'b0, apb_if.penable}, 32'd1);
    @(negedge clk);
    chk("tie_first_done", {30'b0, req_done},    32'b01);
    chk("tie_gap_psel",   {31'b0, apb_if.psel}, 32'd0);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("tie_second_psel",    {31'b0, apb_if.psel},    32'd1);
    chk("tie_second_penable", {31'b0, apb_if.penable}, 32'd0);
    chk("tie_second_paddr",   {20'b0, apb_if.paddr},   32'h008);
    chk("tie_second_pwdata",  apb_if.pwdata,           32'hBBBB_0000);
    chk("tie_second_pstrb",   {28'b0, apb_if.pstrb},   32'hC);
    @(negedge clk);
    chk("tie_second_penable2", {31'b0, apb_if.penable}, 32'd1);
    @(negedge clk);
    chk("tie_second_done", {30'b0, req_done}, 32'b10);
    clear_req();
    apb_if.pready = 1'b0;
    @(negedge clk);
    chk("tie_idle_done", {30'b0, req_done}, 32'd0);

    // Table-driven single transfers
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // Reset asserted during ACCESS drops the transfer; request re-issued.
    @(negedge clk);
    drive_req(1, 1'b0, 12'h0AB, 32'h0, 4'h0);
    apb_if.pready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rr_in_access", {31'b0, apb_if.penable}, 32'd1);
    preset = 1'b1;
    #1;
    chk("rr_psel_low",    {31'b0, apb_if.psel},    32'd0);
    chk("rr_penable_low", {31'b0, apb_if.penable}, 32'd0);
    chk("rr_no_done",     {30'b0, req_done},       32'd0);
    @(negedge clk);
    preset = 1'b0;
    #1;
    chk("rr_no_done_after", {30'b0, req_done}, 32'd0);
    @(negedge clk);
    chk("rr_reissue_psel",    {31'b0, apb_if.psel},    32'd1);
    chk("rr_reissue_penable", {31'b0, apb_if.penable}, 32'd0);
    chk("rr_reissue_paddr",   {20'b0, apb_if.paddr},   32'h0AB);
    apb_if.pready = 1'b1;
    apb_if.prdata = 32'h5A5A_1234;
    apb_if.pslverr = 1'b0;
    @(negedge clk);
    chk("rr_reissue_access", {31'b0, apb_if.penable}, 32'd1);
    @(negedge clk);
    chk("rr_reissue_done",  {30'b0, req_done}, 32'b10);
    chk("rr_reissue_rdata", rsp_rdata,         32'h5A5A_1234);
    clear_req();
    apb_if.pready = 1'b0;
    @(negedge clk);

    // Completer that never raises pready.
    @(negedge clk);
    drive_req(0, 1'b0, 12'h010, 32'h0, 4'h0);
    apb_if.pready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stuck_access", {31'b0, apb_if.penable}, 32'd1);
`ifdef APB_TIMEOUT_EN
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (req_done != 2'b00) begin
        k = c;
        break;
      end
    end
    chk("timeout_cycle", k,                  32'd16);
    chk("timeout_done",  {30'b0, req_done},  32'b01);
    chk("timeout_err",   {31'b0, rsp_err},   32'd1);
    chk("timeout_rdata", rsp_rdata,          32'd0);
    clear_req();
    @(negedge clk);
`else
    seen_bad = 1'b0;
    k = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (apb_if.penable !== 1'b1 || req_done !== 2'b00) seen_bad = 1'b1;
    end
    chk("hang_no_exit", {31'b0, seen_bad},          32'd0);
    chk("hang_penable", {31'b0, apb_if.penable},    32'd1);
    chk("hang_psel",    {31'b0, apb_if.psel},       32'd1);
    clear_req();
    do_reset();
    #1;
    chk("hang_reset_psel", {31'b0, apb_if.psel}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
